// File: rtl/ram_arbiter_2p_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-port RAM arbiter.
//   state_t      - arbiter FSM states (IDLE, ACCESS, TURN)
//   DEF_ADDR_W   - default RAM address width (16 words)
//   DEF_DATA_W   - default RAM data width
//   port_onehot  - port index -> one-hot 2-bit vector
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_2p_if.sv
// ram_arbiter_2p_if: client-side bus of the two-port RAM arbiter.
//   req_i    - per-port request, held until that port's gnt_o bit is seen
//   wr_i     - per-port operation (1 = write, 0 = read)
//   addr_i   - per-port address, port n at [n*ADDR_W +: ADDR_W]
//   wdata_i  - per-port write data, same packing
//   gnt_o    - one-hot grant pulse
//   rvalid_o - one-hot read-data-valid pulse
//   rdata_o  - registered read data
// Modports: master = the two clients, slave = the arbiter.
interface ram_arbiter_2p_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [1:0]          req_i;
  logic [1:0]          wr_i;
  logic [2*ADDR_W-1:0] addr_i;
  logic [2*DATA_W-1:0] wdata_i;
  logic [1:0]          gnt_o;
  logic [1:0]          rvalid_o;
  logic [DATA_W-1:0]   rdata_o;

  modport master (
    output req_i, wr_i, addr_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, wr_i, addr_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );

endinterface

// File: rtl/ram_arbiter_2p_rr_arb2.sv
// rr_arb2: two-requester tie-break.
//   req  - request vector
//   last - port granted most recently
//   gnt  - one-hot winner (zero when no request)
// A single request always wins. On a tie the port not granted last wins,
// unless RAM_ARB_FIXED_PRIO_EN is defined, in which case port 0 always wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  wire unused_last = last;
`endif

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        gnt = 2'b01;
`else
        gnt = last ? 2'b01 : 2'b10;
`endif
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ram_arbiter_2p.sv
// ram_arbiter_2p: two clients sharing one single-port RAM.
//   clk, rst   - clock, synchronous active-high reset
//   bus        - client bus (ram_arbiter_2p_if.slave)
//   busy_o     - high whenever the FSM is not in IDLE
//   ram_we     - RAM write strobe
//   ram_enable - RAM read enable
//   ram_addr   - RAM address (latched from the winning port)
//   ram_data   - bidirectional RAM data; driven only during write accesses
// Each access: IDLE (arbitrate, latch) -> ACCESS x ACC_CYCLES -> TURN, where
// TURN leaves the bus undriven for a cycle and carries the read-valid pulse.
// Optional macro RAM_ARB_FIXED_PRIO_EN switches the tie-break in rr_arb2.
module ram_arbiter_2p
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ACC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_arbiter_2p_if.slave   bus,
  output logic              busy_o,
  output logic              ram_we,
  output logic              ram_enable,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data
);

  state_t state_reg, state_next;

  logic              wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              owner_reg;
  logic              last_reg;
  logic [1:0]        gnt_reg;
  logic [1:0]        cnt_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic [1:0]        grant;
  logic              win;
  logic              acc_last;
  logic [1:0]        rvalid_next;
  logic              ram_drive;

  logic [ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0] wdata_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign addr_arr[gi]  = bus.addr_i[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = bus.wdata_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arb2 u_arb (
    .req  (bus.req_i),
    .last (last_reg),
    .gnt  (grant)
  );

  assign win      = grant[1];
  assign acc_last = (cnt_reg == 2'(ACC_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|bus.req_i) state_next = ACCESS;
      ACCESS:  if (acc_last)   state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy_o      = (state_reg != IDLE);
    ram_we      = (state_reg == ACCESS) &&  wr_reg;
    ram_enable  = (state_reg == ACCESS) && !wr_reg;
    rvalid_next = ((state_reg == TURN) && !wr_reg) ? port_onehot(owner_reg) : 2'b00;
    ram_drive   = ram_we && !ram_enable;
  end

  // Access datapath: the winner's request is latched at the IDLE->ACCESS
  // edge so clients may change their inputs as soon as they see the grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      gnt_reg   <= 2'b00;
      cnt_reg   <= 2'd0;
      rdata_reg <= '0;
    end else begin
      gnt_reg <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (|bus.req_i) begin
            wr_reg    <= bus.wr_i[win];
            addr_reg  <= addr_arr[win];
            wdata_reg <= wdata_arr[win];
            owner_reg <= win;
            last_reg  <= win;
            gnt_reg   <= grant;
            cnt_reg   <= 2'd0;
          end
        end
        ACCESS: begin
          cnt_reg <= cnt_reg + 2'd1;
          // Read data is taken on the closing edge of the final ACCESS cycle.
          if (acc_last && !wr_reg) rdata_reg <= ram_data;
        end
        default: ;
      endcase
    end
  end

  assign ram_addr     = addr_reg;
  assign ram_data     = ram_drive ? wdata_reg : {DATA_W{1'bz}};
  assign bus.gnt_o    = gnt_reg;
  assign bus.rvalid_o = rvalid_next;
  assign bus.rdata_o  = rdata_reg;

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// tb_ram_arbiter_2p: scoreboard bench for ram_arbiter_2p. Expected grants and
// read results are queued when requests are issued and popped by a monitor
// when the DUT pulses gnt_o / rvalid_o. A second instance (ACC_CYCLES=3)
// covers stretched accesses. Honors RAM_ARB_FIXED_PRIO_EN in its model.
module tb_ram_arbiter_2p;

  typedef struct packed { logic wr; logic [3:0] addr; logic [7:0] data; } op_t;
  typedef struct packed { logic [1:0] gnt; logic wr; logic [3:0] addr; logic [7:0] data; } exp_gnt_t;
  typedef struct packed { logic [1:0] port; logic [7:0] data; } exp_rd_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  // main instance
  ram_arbiter_2p_if #(.ADDR_W(4), .DATA_W(8)) bus_if();
  logic       busy_o, ram_we, ram_enable;
  logic [3:0] ram_addr;
  wire  [7:0] ram_data;

  ram_arbiter_2p #(.ADDR_W(4), .DATA_W(8), .ACC_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .busy_o(busy_o), .ram_we(ram_we),
    .ram_enable(ram_enable), .ram_addr(ram_addr), .ram_data(ram_data)
  );

  logic [7:0] mem [16];
  assign ram_data = (ram_enable && !ram_we) ? mem[ram_addr] : 8'bz;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

  // ACC_CYCLES=3 instance
  ram_arbiter_2p_if #(.ADDR_W(4), .DATA_W(8)) bus3();
  logic       busy3, ram_we3, ram_en3;
  logic [3:0] ram_addr3;
  wire  [7:0] ram_data3;

  ram_arbiter_2p #(.ADDR_W(4), .DATA_W(8), .ACC_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .busy_o(busy3), .ram_we(ram_we3),
    .ram_enable(ram_en3), .ram_addr(ram_addr3), .ram_data(ram_data3)
  );
  assign ram_data3 = (ram_en3 && !ram_we3) ? {4'h5, ram_addr3} : 8'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  op_t        pq0 [$];
  op_t        pq1 [$];
  exp_gnt_t   gnt_q [$];
  exp_rd_t    rd_q [$];
  logic [7:0] m_mem [16];
  int         m_last = 1;
  int         since_gnt = 100;
  int         rv_count = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic int model_pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 1) ? 0 : 1;
`endif
    end
    return r0 ? 0 : 1;
  endfunction

  // monitor / scoreboard consumer
  always @(negedge clk) begin
    exp_gnt_t eg;
    exp_rd_t  er;
    if (rst) begin
      since_gnt = 100;
    end else begin
      since_gnt++;
      chk("we_en_excl", 32'(ram_we & ram_enable), 0);
      if (bus_if.gnt_o != 2'b00) begin
        if (gnt_q.size() == 0) chk("gnt_unexp", 32'(bus_if.gnt_o), 0);
        else begin
          eg = gnt_q.pop_front();
          chk("gnt", 32'(bus_if.gnt_o), 32'(eg.gnt));
          chk("gnt_gap", 32'(since_gnt >= 3), 1);
          chk("ram_we", 32'(ram_we), 32'(eg.wr));
          chk("ram_en", 32'(ram_enable), 32'(!eg.wr));
          chk("ram_addr", 32'(ram_addr), 32'(eg.addr));
          if (eg.wr) chk("ram_wdata", 32'(ram_data), 32'(eg.data));
          $display("gnt=%b wr=%0d addr=%0d data=%02h", bus_if.gnt_o, eg.wr, eg.addr, eg.data);
        end
        since_gnt = 0;
      end
      if (bus_if.rvalid_o != 2'b00) begin
        rv_count++;
        if (rd_q.size() == 0) chk("rvalid_unexp", 32'(bus_if.rvalid_o), 0);
        else begin
          er = rd_q.pop_front();
          chk("rvalid", 32'(bus_if.rvalid_o), 32'(er.port));
          chk("rdata", 32'(bus_if.rdata_o), 32'(er.data));
          $display("rvalid=%b rdata=%02h exp=%02h", bus_if.rvalid_o, bus_if.rdata_o, er.data);
        end
      end
    end
  end

  task automatic set_port(input int p, input op_t op);
    if (p == 0) begin
      bus_if.wr_i[0] = op.wr; bus_if.addr_i[3:0] = op.addr; bus_if.wdata_i[7:0] = op.data;
    end else begin
      bus_if.wr_i[1] = op.wr; bus_if.addr_i[7:4] = op.addr; bus_if.wdata_i[15:8] = op.data;
    end
  endtask

  // Build expectations for pq0/pq1, then drive them; each port re-requests
  // with its next op in the cycle its grant is seen.
  task automatic run_ops();
    int  i0 = 0;
    int  i1 = 0;
    int  p;
    int  n;
    op_t op;
    while (i0 < pq0.size() || i1 < pq1.size()) begin
      p = model_pick(i0 < pq0.size(), i1 < pq1.size(), m_last);
      if (p == 0) begin op = pq0[i0]; i0++; end
      else        begin op = pq1[i1]; i1++; end
      gnt_q.push_back({(p == 0) ? 2'b01 : 2'b10, op.wr, op.addr, op.data});
      if (op.wr) m_mem[op.addr] = op.data;
      else       rd_q.push_back({(p == 0) ? 2'b01 : 2'b10, m_mem[op.addr]});
      m_last = p;
    end
    i0 = 0; i1 = 0;
    if (pq0.size() > 0) begin set_port(0, pq0[0]); bus_if.req_i[0] = 1'b1; end
    if (pq1.size() > 0) begin set_port(1, pq1[0]); bus_if.req_i[1] = 1'b1; end
    n = 0;
    while (bus_if.req_i != 2'b00 && n < 2000) begin
      @(negedge clk);
      n++;
      if (bus_if.gnt_o[0]) begin
        i0++;
        if (i0 < pq0.size()) set_port(0, pq0[i0]); else bus_if.req_i[0] = 1'b0;
      end
      if (bus_if.gnt_o[1]) begin
        i1++;
        if (i1 < pq1.size()) set_port(1, pq1[i1]); else bus_if.req_i[1] = 1'b0;
      end
    end
    chk("run_timeout", 32'(bus_if.req_i), 0);
    bus_if.req_i = 2'b00;
    n = 0;
    while (busy_o && n < 100) begin @(negedge clk); n++; end
    pq0.delete();
    pq1.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_gnt", 32'(bus_if.gnt_o), 0);
    chk("rst_rvalid", 32'(bus_if.rvalid_o), 0);
    chk("rst_rdata", 32'(bus_if.rdata_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_en", 32'(ram_enable), 0);
    chk("rst_addr", 32'(ram_addr), 0);
  endtask

  initial begin
    int  n;
    int  k;
    int  en_cnt;
    int  rv_base;
    bit  got_rv;

    rst = 1'b1;
    bus_if.req_i = 2'b00; bus_if.wr_i = 2'b00; bus_if.addr_i = '0; bus_if.wdata_i = '0;
    bus3.req_i = 2'b00; bus3.wr_i = 2'b00; bus3.addr_i = '0; bus3.wdata_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // simultaneous writes from reset: port 0 first
    pq0.push_back({1'b1, 4'd1, 8'h11});
    pq1.push_back({1'b1, 4'd2, 8'h22});
    run_ops();
    // port 0 re-requests: round-robin alternates, fixed priority repeats p0
    pq0.push_back({1'b1, 4'd4, 8'h44});
    pq0.push_back({1'b1, 4'd5, 8'h55});
    pq1.push_back({1'b1, 4'd6, 8'h66});
    run_ops();

    // write then read back through the other port
    pq0.push_back({1'b1, 4'd3, 8'hA5});
    run_ops();
    pq1.push_back({1'b0, 4'd3, 8'h00});
    run_ops();

    // continuous requests on both ports, mixed reads and writes
    for (int i = 0; i < 4; i++) begin
      pq0.push_back({1'b1, 4'(8 + i), 8'(8'h80 + i)});
      pq1.push_back({1'b0, 4'(1 + i), 8'h00});
    end
    run_ops();

    // fill then read the whole RAM
    for (int i = 0; i < 16; i++) pq0.push_back({1'b1, 4'(i), 8'(i)});
    run_ops();
    rv_base = rv_count;
    for (int i = 0; i < 16; i++) pq0.push_back({1'b0, 4'(i), 8'h00});
    run_ops();
    chk("rvalid_count16", 32'(rv_count - rv_base), 16);

    // reset in the ACCESS cycle of a read
    gnt_q.push_back({2'b01, 1'b0, 4'd7, 8'h00});
    set_port(0, {1'b0, 4'd7, 8'h00});
    bus_if.req_i = 2'b01;
    n = 0;
    while (!bus_if.gnt_o[0] && n < 50) begin @(negedge clk); n++; end
    chk("abort_gnt_seen", 32'(bus_if.gnt_o[0]), 1);
    #1;
    bus_if.req_i = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    m_last = 1;
    repeat (4) @(negedge clk);
    chk("abort_queue_empty", 32'(gnt_q.size()), 0);

    // after reset the tie goes to port 0 again
    pq0.push_back({1'b1, 4'd0, 8'h3C});
    pq1.push_back({1'b1, 4'd1, 8'h3D});
    run_ops();
    pq1.push_back({1'b0, 4'd0, 8'h00});
    pq0.push_back({1'b0, 4'd1, 8'h00});
    run_ops();

    // ACC_CYCLES=3 read on port 1
    bus3.wr_i = 2'b00;
    bus3.addr_i = {4'hC, 4'h0};
    bus3.req_i = 2'b10;
    @(posedge clk);
    k = 0; en_cnt = 0; got_rv = 1'b0;
    while (!got_rv && k < 20) begin
      @(negedge clk);
      k++;
      if (ram_en3) en_cnt++;
      chk("acc3_excl", 32'(ram_we3 & ram_en3), 0);
      if (bus3.gnt_o != 2'b00) begin
        chk("acc3_gnt", 32'(bus3.gnt_o), 32'(2'b10));
        chk("acc3_gnt_cycle", 32'(k), 1);
        bus3.req_i = 2'b00;
      end
      if (bus3.rvalid_o != 2'b00) begin
        got_rv = 1'b1;
        chk("acc3_rvalid", 32'(bus3.rvalid_o), 32'(2'b10));
        chk("acc3_rv_cycle", 32'(k), 4);
        chk("acc3_rdata", 32'(bus3.rdata_o), 32'(8'h5C));
        $display("acc3 rvalid=%b rdata=%02h cycle=%0d", bus3.rvalid_o, bus3.rdata_o, k);
      end
    end
    chk("acc3_rv_seen", 32'(got_rv), 1);
    repeat (3) begin
      @(negedge clk);
      if (ram_en3) en_cnt++;
    end
    chk("acc3_en_cycles", 32'(en_cnt), 3);
    chk("acc3_idle", 32'(busy3), 0);

    chk("gnt_q_drained", 32'(gnt_q.size()), 0);
    chk("rd_q_drained", 32'(rd_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_arbiter_2p.md
RAM_ARBITER_2P -- requirements
Module: ram_arbiter_2p

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, RAM address width (16 words).
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter ACC_CYCLES, default 1, range 1..4, cycles ram_we/ram_enable are held per access.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_i  input  2  per-port access request; held until that port's gnt_o bit is seen.
REQ-007 wr_i  input  2  per-port operation: 1 = write, 0 = read; stable while req_i high.
REQ-008 addr_i  input  2*ADDR_W  per-port address (port n at bits [n*ADDR_W +: ADDR_W]).
REQ-009 wdata_i  input  2*DATA_W  per-port write data, same packing.
REQ-010 gnt_o  output  2  one-hot, one-cycle grant pulse.
REQ-011 rvalid_o  output  2  one-hot, one-cycle read-data-valid pulse.
REQ-012 rdata_o  output  DATA_W  registered read data; valid when any rvalid_o bit is high.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 ram_we  output  1  RAM write strobe.
REQ-015 ram_enable  output  1  RAM read enable.
REQ-016 ram_addr  output  ADDR_W  RAM address.
REQ-017 ram_data  inout  DATA_W  RAM data bus; driven only when ram_we=1 and ram_enable=0, else high-Z.

Function
REQ-018 FSM SHALL have states IDLE, ACCESS, TURN; IDLE->ACCESS on any req_i bit, ACCESS->TURN after ACC_CYCLES cycles, TURN->IDLE unconditionally.
REQ-019 In IDLE with requests present, SHALL register winner's wr/addr/wdata and pulse winner's gnt_o bit in the first ACCESS cycle.
REQ-020 Default arbitration SHALL be round-robin: single request wins; on tie, port not granted last wins.
REQ-021 ACCESS write: ram_we=1, ram_enable=0, ram_data=latched wdata, ram_addr=latched addr.
REQ-022 ACCESS read: ram_we=0, ram_enable=1, ram_data high-Z; ram_data sampled into rdata_o at end of last ACCESS cycle.
REQ-023 TURN: ram_we=0, ram_enable=0, ram_data high-Z; for a read, owning port's rvalid_o bit high this cycle only.
REQ-024 ram_we and ram_enable SHALL never be high simultaneously; bus SHALL be undriven for at least one cycle between accesses.
REQ-025 Per-access latency SHALL be ACC_CYCLES+2 cycles from request sampled in IDLE to return to IDLE; rvalid at cycle ACC_CYCLES+1 after the IDLE sample edge.
REQ-026 rdata_o SHALL hold its value until the next read capture; writes SHALL NOT alter rdata_o.
REQ-027 Requests arriving outside IDLE SHALL wait, not be dropped; no gnt_o issued outside the IDLE->ACCESS transition.

Reset
REQ-028 On rst: state=IDLE, gnt_o=0, rvalid_o=0, rdata_o=0, busy_o=0, ram_we=0, ram_enable=0, ram_addr=0, ram_data high-Z, last-grant pointer=port 1.
REQ-029 rst during ACCESS/TURN SHALL abandon the access with no rvalid_o pulse; reset dominates all other events.

Configuration
REQ-030 With RAM_ARB_FIXED_PRIO_EN defined, tie-break SHALL be fixed: port 0 always wins; without it, round-robin per REQ-020.

Structure
REQ-031 Package ram_arb_pkg SHALL hold the FSM state enum and default ADDR_W/DATA_W constants.
REQ-032 Tie-break logic SHALL be sub-module rr_arb2 (req[1:0], last pointer -> one-hot grant), honoring RAM_ARB_FIXED_PRIO_EN.

Verification
REQ-033 Port 0 writes addr 3 = 0xA5 (ACC_CYCLES=1) -> ram_we=1 one cycle, ram_addr=3, ram_data=0xA5, gnt_o=01; later port 1 reads addr 3 -> rdata_o=0xA5, rvalid_o=10.
REQ-034 Both ports request from reset (p0 write addr 1 = 0x11, p1 write addr 2 = 0x22) -> p0 granted first, p1 next; with macro and p0 re-requesting, p0 wins twice in a row.
REQ-035 Continuous requests on both ports for 8 accesses -> grants alternate 01,10,...; ram_we and ram_enable never both 1; idle TURN cycle between every access.
REQ-036 Write 0..15 to addr 0..15 then read all -> rdata_o equals address each time; rvalid_o count = 16.
REQ-037 Assert rst in ACCESS of a read -> next cycle all outputs at reset values, ram_data high-Z, no rvalid_o pulse.
REQ-038 ACC_CYCLES=3 read -> ram_enable high exactly 3 cycles; rvalid_o 4 cycles after IDLE sample edge.
